// File: rtl/conv_reset_pkg.sv
// Shared types and default constants for the integrator/ramp reset controller.
package conv_reset_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_t;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT     = 4000;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 4;

  // Width of a saturating run counter that must be able to hold len.
  function automatic int run_w(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/conv_reset_chan.sv
// One reset channel: comparator synchroniser, optional run-length filter
// (CONV_CMP_FILTER_EN), IDLE/ACTIVE FSM, duration counter and sticky timeout flag.
module conv_reset_chan
  import conv_reset_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             conv_rise,
  input  logic             ch_en,
  input  logic             cmp_in,
  input  logic             err_clr,
  output logic             reset_out,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             timeout_err
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1 || TIMEOUT < 1 ||
      TIMEOUT >= (64'd1 << CNT_W)) begin : g_param_err
    $error("conv_reset_chan: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] cmp_sync;
  logic                   cmp_s;
  logic                   cmp_hit;
  chan_state_t            state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_sync <= '0;
    end else begin
      cmp_sync <= {cmp_sync[SYNC_STAGES-2:0], cmp_in};
    end
  end

  assign cmp_s = cmp_sync[SYNC_STAGES-1];

`ifdef CONV_CMP_FILTER_EN
  localparam int               RUN_W   = run_w(FILT_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);
  localparam logic [RUN_W-1:0] RUN_THR = RUN_W'(FILT_LEN - 1);

  logic [RUN_W-1:0] run;

  // run counts the consecutive high samples before this one, so the current
  // sample completes the qualification without an extra cycle of delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (!cmp_s) begin
      run <= '0;
    end else if (run != RUN_MAX) begin
      run <= run + 1'b1;
    end
  end

  assign cmp_hit = cmp_s && (run >= RUN_THR);
`else
  assign cmp_hit = cmp_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      reset_out   <= 1'b0;
      busy        <= 1'b0;
      cnt_out     <= '0;
      cnt_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      // A timeout assignment further down overrides this clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (conv_rise && ch_en) begin
            if (cmp_hit) begin
              cnt_out   <= '0;
              cnt_valid <= 1'b1;
            end else begin
              state     <= ACTIVE;
              reset_out <= 1'b1;
              busy      <= 1'b1;
              cnt       <= CNT_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (!ch_en) begin
            state     <= IDLE;
            reset_out <= 1'b0;
            busy      <= 1'b0;
          end else if (cmp_hit) begin
            state     <= IDLE;
            reset_out <= 1'b0;
            busy      <= 1'b0;
            cnt_out   <= cnt;
            cnt_valid <= 1'b1;
          end else if (cnt == CNT_LIMIT) begin
            state       <= IDLE;
            reset_out   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          reset_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/conv_reset_ctrl.sv
// Multi-channel integrator reset controller: shared conv synchroniser and edge
// detector feeding CHANNELS independent channels. Optional macro: CONV_CMP_FILTER_EN.
module conv_reset_ctrl
  import conv_reset_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      conv,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       cmp_in,
  input  logic                      err_clr,
  output logic [CHANNELS-1:0]       reset_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] cnt_out,
  output logic [CHANNELS-1:0]       cnt_valid,
  output logic [CHANNELS-1:0]       timeout_err
);

  logic [SYNC_STAGES-1:0] conv_sync;
  logic                   conv_s;
  logic                   conv_s_d;
  logic                   conv_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_sync <= '0;
      conv_s_d  <= 1'b0;
    end else begin
      conv_sync <= {conv_sync[SYNC_STAGES-2:0], conv};
      conv_s_d  <= conv_s;
    end
  end

  assign conv_s    = conv_sync[SYNC_STAGES-1];
  assign conv_rise = conv_s & ~conv_s_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    conv_reset_chan #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .conv_rise   (conv_rise),
      .ch_en       (ch_en[i]),
      .cmp_in      (cmp_in[i]),
      .err_clr     (err_clr),
      .reset_out   (reset_out[i]),
      .busy        (busy[i]),
      .cnt_out     (cnt_out[i*CNT_W +: CNT_W]),
      .cnt_valid   (cnt_valid[i]),
      .timeout_err (timeout_err[i])
    );
  end

endmodule
